// File: rtl/led_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_pkg
// Description : Shared constants and helpers for the LED PWM driver.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pwm_pkg;

    localparam int NUM_LEDS              = 4;
    localparam int SEL_W                 = 2;
    localparam int DEFAULT_WIDTH         = 8;
    localparam int DEFAULT_PRESCALE      = 4;
    localparam int DEFAULT_BLINK_PERIODS = 16;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_driver_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM channel: pending/active brightness, compare and
//               registered LED output.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_level,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_pwm_cnt,
    input  logic             i_blank,
    output logic             o_led
);

    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_active;
    logic             w_on;

    // All-ones is forced fully on so the top level reaches 100% duty.
    assign w_on = (r_active == {WIDTH{1'b1}}) || (i_pwm_cnt < r_active);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
            r_active  <= '0;
            o_led     <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_pending <= i_wr_level;
            end
            // A write landing on the load cycle goes straight to active.
            if (i_load) begin
                r_active <= i_wr_en ? i_wr_level : r_pending;
            end
            o_led <= w_on & ~i_blank;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_driver
// Description : Four-channel LED PWM driver with period-aligned level updates.
//               Optional blink support when LED_PWM_BLINK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int PRESCALE      = DEFAULT_PRESCALE,
    parameter int BLINK_PERIODS = DEFAULT_BLINK_PERIODS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [SEL_W-1:0]    i_wr_sel,
    input  logic [WIDTH-1:0]    i_wr_level,
`ifdef LED_PWM_BLINK_EN
    input  logic [NUM_LEDS-1:0] i_blink,
`endif
    output logic [NUM_LEDS-1:0] o_leds,
    output logic                o_period_start
);

    localparam int PRE_W = cnt_width(PRESCALE);

    logic [PRE_W-1:0]    r_pre_cnt;
    logic [WIDTH-1:0]    r_pwm_cnt;
    logic                w_tick;
    logic                w_load;
    logic [NUM_LEDS-1:0] w_blank;
    logic [NUM_LEDS-1:0] w_wr_en;

    assign w_tick = (r_pre_cnt == PRE_W'(PRESCALE - 1));
    assign w_load = w_tick && (r_pwm_cnt == {WIDTH{1'b1}});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre_cnt      <= '0;
            r_pwm_cnt      <= '0;
            o_period_start <= 1'b0;
        end else begin
            r_pre_cnt      <= w_tick ? '0 : r_pre_cnt + 1'b1;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
            o_period_start <= (r_pwm_cnt == '0) && (r_pre_cnt == '0);
        end
    end

`ifdef LED_PWM_BLINK_EN
    localparam int BLK_W = cnt_width(BLINK_PERIODS);

    logic [BLK_W-1:0]    r_blink_cnt;
    logic                r_blink_off;
    logic [NUM_LEDS-1:0] r_blink_mask;

    // Phase and mask only move on load events so a period is never split.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_blink_cnt  <= '0;
            r_blink_off  <= 1'b0;
            r_blink_mask <= '0;
        end else if (w_load) begin
            r_blink_mask <= i_blink;
            if (r_blink_cnt == BLK_W'(BLINK_PERIODS - 1)) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_blank = r_blink_off ? r_blink_mask : '0;
`else
    assign w_blank = '0;
`endif

    for (genvar n = 0; n < NUM_LEDS; n++) begin : g_chan
        assign w_wr_en[n] = i_wr_en && (i_wr_sel == SEL_W'(n));

        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_wr_en    (w_wr_en[n]),
            .i_wr_level (i_wr_level),
            .i_load     (w_load),
            .i_pwm_cnt  (r_pwm_cnt),
            .i_blank    (w_blank[n]),
            .o_led      (o_leds[n])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pwm_driver
// Description : Self-checking bench for led_pwm_driver (WIDTH=4, PRESCALE=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_driver;

    localparam int W   = 4;
    localparam int PS  = 2;
    localparam int PER = PS << W;
    localparam int BP  = 2;

    typedef logic [3:0][PER-1:0] exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [1:0]   wr_sel = '0;
    logic [W-1:0] wr_level = '0;
    logic [3:0]   blink = '0;
    logic [3:0]   leds;
    logic         period_start;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   lvl[4] = '{0, 0, 0, 0};
    exp_t sb_q[$];

    led_pwm_driver #(
        .WIDTH         (W),
        .PRESCALE      (PS),
        .BLINK_PERIODS (BP)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wr_en),
        .i_wr_sel       (wr_sel),
        .i_wr_level     (wr_level),
`ifdef LED_PWM_BLINK_EN
        .i_blink        (blink),
`endif
        .o_leds         (leds),
        .o_period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PER-1:0] pat(input int l);
        logic [PER-1:0] one;
        one = 1;
        if (l == (1 << W) - 1) return '1;
        return (one << (PS * l)) - 1;
    endfunction

    function automatic exp_t make_exp(input int l0, input int l1, input int l2, input int l3);
        exp_t e;
        e[0] = pat(l0);
        e[1] = pat(l1);
        e[2] = pat(l2);
        e[3] = pat(l3);
        return e;
    endfunction

    task automatic push_cur();
        sb_q.push_back(make_exp(lvl[0], lvl[1], lvl[2], lvl[3]));
    endtask

    task automatic sync_ps();
        int n;
        n = 0;
        while (period_start !== 1'b1 && n < 3 * PER) begin
            tick();
            n++;
        end
        if (period_start !== 1'b1) begin
            n_cmp++;
            n_mis++;
            $display("FAIL sync_ps: period_start=%b after %0d cycles, required 1", period_start, n);
        end
    endtask

    // Capture one period starting at the current period_start sample, issuing
    // up to two writes at given in-period offsets, then score it.
    task automatic measure(input string name, input int nw,
                           input int off0, input int sel0, input int lv0,
                           input int off1, input int sel1, input int lv1);
        exp_t got;
        exp_t exp;
        int   ps_cnt;
        got    = '0;
        ps_cnt = 0;
        for (int k = 0; k < PER; k++) begin
            for (int c = 0; c < 4; c++) got[c][k] = leds[c];
            if (period_start === 1'b1) ps_cnt++;
            wr_en = 1'b0;
            if (nw > 0 && k == off0) begin
                wr_en = 1'b1; wr_sel = sel0[1:0]; wr_level = lv0[W-1:0];
            end else if (nw > 1 && k == off1) begin
                wr_en = 1'b1; wr_sel = sel1[1:0]; wr_level = lv1[W-1:0];
            end
            tick();
        end
        wr_en = 1'b0;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_mis++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            exp = sb_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                if (got[c] !== exp[c]) begin
                    n_mis++;
                    $display("FAIL %s ch%0d: pattern %h, required %h", name, c, got[c], exp[c]);
                    break;
                end
            end
        end
        n_cmp++;
        if (ps_cnt !== 1 || period_start !== 1'b1) begin
            n_mis++;
            $display("FAIL %s period_start: pulses=%0d next=%b, required 1 and 1", name, ps_cnt, period_start);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (leds !== 4'b0 || period_start !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_hold: leds=%b ps=%b, required 0000 0", leds, period_start);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (period_start !== 1'b1 || leds !== 4'b0) begin
            n_mis++;
            $display("FAIL reset_first_ps: ps=%b leds=%b, required 1 0000", period_start, leds);
        end
        tick();
        n_cmp++;
        if (period_start !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_ps_width: ps=%b, required 0", period_start);
        end
        sync_ps();
        push_cur();
        lvl[0] = 15;
        push_cur();
        measure("ch0_15_pre", 1, 2, 0, 15, -1, 0, 0);
        measure("ch0_15", 0, -1, 0, 0, -1, 0, 0);
        repeat (5) tick();
        n_cmp++;
        if (leds[0] !== 1'b1) begin
            n_mis++;
            $display("FAIL pre_async_reset: led0=%b, required 1", leds[0]);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (leds !== 4'b0 || period_start !== 1'b0) begin
            n_mis++;
            $display("FAIL async_reset: leds=%b ps=%b, required 0000 0", leds, period_start);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        n_cmp++;
        if (period_start !== 1'b1) begin
            n_mis++;
            $display("FAIL post_reset_ps: ps=%b, required 1", period_start);
        end
        for (int c = 0; c < 4; c++) lvl[c] = 0;
        push_cur();
        measure("post_reset_dark", 0, -1, 0, 0, -1, 0, 0);
    endtask

    task automatic test_duty();
        push_cur();
        lvl[0] = 4;
        push_cur();
        push_cur();
        measure("duty_write", 1, 5, 0, 4, -1, 0, 0);
        measure("duty_p1", 0, -1, 0, 0, -1, 0, 0);
        measure("duty_p2", 0, -1, 0, 0, -1, 0, 0);
    endtask

    task automatic test_extremes();
        push_cur();
        lvl[1] = 0;
        lvl[2] = 15;
        push_cur();
        measure("ext_write", 2, 3, 1, 0, 7, 2, 15);
        measure("ext_p1", 0, -1, 0, 0, -1, 0, 0);
    endtask

    task automatic test_back_to_back();
        push_cur();
        measure("mid_write", 1, 10, 3, 8, -1, 0, 0);
        lvl[3] = 8;
        push_cur();
        measure("wt_write", 2, 12, 1, 6, PER - 2, 3, 2);
        lvl[1] = 6;
        lvl[3] = 2;
        push_cur();
        measure("wt_result", 0, -1, 0, 0, -1, 0, 0);
    endtask

    task automatic test_last_wins();
        push_cur();
        measure("lw_write", 2, 4, 2, 3, 20, 2, 10);
        lvl[2] = 10;
        push_cur();
        measure("lw_result", 0, -1, 0, 0, -1, 0, 0);
    endtask

`ifdef LED_PWM_BLINK_EN
    task automatic test_blink();
        @(posedge clk);
        #1 rst = 1'b1;
        blink = 4'b0001;
        tick();
        rst = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) lvl[c] = 0;
        push_cur();
        measure("blink_setup", 2, 2, 0, 15, 3, 1, 15);
        for (int p = 1; p <= 6; p++) begin
            sb_q.push_back(make_exp(((p / BP) % 2 == 1) ? 0 : 15, 15, 0, 0));
            measure("blink", 0, -1, 0, 0, -1, 0, 0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_duty();
        test_extremes();
        test_back_to_back();
        test_last_wins();
`ifdef LED_PWM_BLINK_EN
        test_blink();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
